// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with a 2-entry skid buffer.
// Chained instances form the IF/ID, ID/EXE, EXE/MEM and MEM/WB boundaries.
// in_ready comes straight from a flop, so no combinational path runs from
// out_ready back upstream. A synchronous flush kills every buffered payload.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_skid_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Main entry feeds the outputs; the skid entry absorbs a payload that
    // arrives while the main entry is stalled.
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             accept;
    logic             drain;

    // Handshake qualifiers: a payload enters on accept, and the main entry may be replaced on drain.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        accept = 1'b0;
        drain  = 1'b0;
        accept = in_valid & in_ready;
        drain  = ~main_v | out_ready;
    end

    // Entry update: reset and flush discard everything; otherwise refill the main entry from skid, then from input.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
        if (reset || flush) begin
            // NOTE: the data registers are reset as well, so a flushed stage
            // presents a known payload rather than a stale instruction.
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RESET_DATA;
            skid_d <= RESET_DATA;
        end else if (drain) begin
            if (skid_v) begin
                main_v <= 1'b1;
                main_d <= skid_d;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_v <= 1'b1;
                main_d <= in_data;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

`ifdef PIPE_STALL_CNT_EN
    // Stall counter: counts edges where the output is held by backpressure, saturates, and is cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!flush && main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
